// File: rtl/fetch_sequencer.sv
// Instruction fetch control: drives the program counter, reads opcode/immediate words from
// memory, hands instructions to the decoder and turns jump requests into counter loads.
module fetch_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMM_BIT    = 15,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  pcNotOE,
  output logic                  pcInc,
  output logic                  pcNotLoad,
  output logic                  memReq,
  input  logic                  memAck,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  instrValid,
  input  logic                  instrReady,
  input  logic                  jumpReq,
  output logic                  jumpAck,
  output logic                  fault
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StFetchOp  = 3'd1;
  localparam logic [2:0] StFetchImm = 3'd2;
  localparam logic [2:0] StIssue    = 3'd3;
  localparam logic [2:0] StJump     = 3'd4;
  localparam logic [2:0] StHalt     = 3'd5;

  localparam logic [7:0] WaitLimit = WAIT_LIMIT[7:0];

  logic [2:0]            state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  fetching;

  assign fetching = (state_q == StFetchOp) || (state_q == StFetchImm);

  always_comb begin
    state_d = state_q;
    wait_d  = 8'd0;
    instr_d = instr_q;
    imm_d   = imm_q;
    case (state_q)
      StIdle: state_d = StFetchOp;
      StFetchOp, StFetchImm: begin
        if (memAck) begin
          if (state_q == StFetchOp) begin
            instr_d = memData;
            state_d = memData[IMM_BIT] ? StFetchImm : StIssue;
          end else begin
            imm_d   = memData;
            state_d = StIssue;
          end
        end else if (wait_q + 8'd1 == WaitLimit) begin
          // An ack in this last wait cycle wins over the timeout.
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StIssue: begin
        if (instrReady) state_d = jumpReq ? StJump : StFetchOp;
      end
      StJump:  state_d = StFetchOp;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 8'd0;
      instr_q <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
    end
  end

  // pcInc is the only Mealy output; masked during reset so an aborted ack never advances the PC.
  always_comb begin
    pcNotOE    = ~fetching;
    memReq     = fetching;
    pcInc      = fetching & memAck & ~reset;
    pcNotLoad  = (state_q != StJump);
    jumpAck    = (state_q == StJump);
    instrValid = (state_q == StIssue);
    fault      = (state_q == StHalt);
    instr      = instr_q;
    imm        = imm_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, corner-case sequences and a
// randomized run checked against a transaction-level model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset, pcNotOE, pcInc, pcNotLoad, memReq, memAck;
  logic [15:0] memData, instr, imm;
  logic        instrValid, instrReady, jumpReq, jumpAck, fault;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.DATA_WIDTH(16), .IMM_BIT(15), .WAIT_LIMIT(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .pcNotOE    (pcNotOE),
    .pcInc      (pcInc),
    .pcNotLoad  (pcNotLoad),
    .memReq     (memReq),
    .memAck     (memAck),
    .memData    (memData),
    .instr      (instr),
    .imm        (imm),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .jumpReq    (jumpReq),
    .jumpAck    (jumpAck),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  // {pcNotOE, pcInc, pcNotLoad, memReq, instrValid, jumpAck, fault}
  localparam logic [6:0] CIdle  = 7'b1010000;
  localparam logic [6:0] CFetch = 7'b0011000;
  localparam logic [6:0] CFAck  = 7'b0111000;
  localparam logic [6:0] CIssue = 7'b1010100;
  localparam logic [6:0] CJump  = 7'b1000010;
  localparam logic [6:0] CHalt  = 7'b1010001;

  typedef struct {
    logic        rst, ack;
    logic [15:0] data;
    logic        rdy, jreq;
    logic [6:0]  ctl;
    logic [15:0] e_instr, e_imm;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [6:0] ctl_now();
    return {pcNotOE, pcInc, pcNotLoad, memReq, instrValid, jumpAck, fault};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [15:0] d, input logic rdy,
                       input logic j);
    reset = r; memAck = a; memData = d; instrReady = rdy; jumpReq = j;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Transaction-level model state for the random run
  logic [31:0] q[$];
  logic        exp_fetch, exp_jack, exp_halt, exp_idle, partial, jhold;
  logic [15:0] partial_op, last_imm;
  int          run, halt_cycles;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, CIdle,  16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, CFetch, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, CFAck,  16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, CIssue, 16'h1234, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, CFAck,  16'h1234, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, CFetch, 16'h8001, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, CFAck,  16'h8001, 16'h0000};
    for (int i = 7; i < 12; i++)
      vecs[i] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, CIssue, 16'h8001, 16'hBEEF};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, CIssue, 16'h8001, 16'hBEEF};
    vecs[13] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, CJump,  16'h8001, 16'hBEEF};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, CFetch, 16'h8001, 16'hBEEF};
    vecs[15] = '{1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, CFAck,  16'h8001, 16'hBEEF};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, CIssue, 16'h0042, 16'hBEEF};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, CFetch, 16'h0042, 16'hBEEF};

    reset = 1'b1; memAck = 1'b0; memData = '0; instrReady = 1'b0; jumpReq = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].data, vecs[i].rdy, vecs[i].jreq);
      chk($sformatf("vec%0d_ctl", i), {25'd0, ctl_now()}, {25'd0, vecs[i].ctl});
      chk($sformatf("vec%0d_instr", i), {16'd0, instr}, {16'd0, vecs[i].e_instr});
      chk($sformatf("vec%0d_imm", i), {16'd0, imm}, {16'd0, vecs[i].e_imm});
      tick();
    end

    // Timeout: three unacked fetch cycles, then sticky HALT ignoring ack and jump
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0); chk("to_idle", {25'd0, ctl_now()}, {25'd0, CIdle});
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk($sformatf("to_wait%0d", k), {25'd0, ctl_now()}, {25'd0, CFetch});
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 16'h8888, 1'b1, 1'b1);
      chk($sformatf("to_halt%0d", k), {25'd0, ctl_now()}, {25'd0, CHalt});
      tick();
    end
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("to_clear", {25'd0, ctl_now()}, {25'd0, CIdle});
    chk("to_clear_imm", {16'd0, imm}, 32'd0);
    tick();

    // Ack in the last allowed wait cycle is accepted
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk($sformatf("late_wait%0d", k), {25'd0, ctl_now()}, {25'd0, CFetch});
      tick();
    end
    drive(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    chk("late_ack", {25'd0, ctl_now()}, {25'd0, CFAck});
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("late_issue", {25'd0, ctl_now()}, {25'd0, CIssue});
    chk("late_instr", {16'd0, instr}, 32'h0005);
    tick();

    // Reset while fetching with an ack in the same cycle
    drive(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
    chk("rst_mid_req", {31'd0, memReq}, 32'd1);
    chk("rst_mid_inc", {31'd0, pcInc}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("rst_mid_idle", {25'd0, ctl_now()}, {25'd0, CIdle});
    chk("rst_mid_instr", {16'd0, instr}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("rst_mid_fetch", {25'd0, ctl_now()}, {25'd0, CFetch});
    tick();

    // Randomized run against the transaction-level model
    exp_fetch = 0; exp_jack = 0; exp_halt = 0; exp_idle = 0; partial = 0; jhold = 0;
    partial_op = '0; last_imm = '0; run = 0; halt_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        r, a, rdy, nf, nj, ni;
      logic [15:0] d;
      r   = (c == 0) || ($urandom_range(0, 99) < 2) || (halt_cycles > 4);
      a   = ($urandom_range(0, 99) < 65);
      d   = 16'($urandom);
      rdy = ($urandom_range(0, 99) < 60);
      if (!jhold && $urandom_range(0, 99) < 30) jhold = 1'b1;
      drive(r, a, d, rdy, jhold);
      if (r) begin
        chk("rnd_rst_inc", {31'd0, pcInc}, 32'd0);
      end else begin
        chk($sformatf("rnd%0d_ctl", c), {25'd0, ctl_now()},
            {25'd0, !exp_fetch, exp_fetch & a, !exp_jack, exp_fetch, q.size() > 0, exp_jack,
             exp_halt});
        if (q.size() > 0) chk($sformatf("rnd%0d_word", c), {instr, imm}, q[0]);
      end
      nf = 0; nj = 0; ni = 0;
      if (r) begin
        q.delete(); partial = 0; last_imm = '0; run = 0; exp_halt = 0; jhold = 0;
        halt_cycles = 0; ni = 1;
      end else if (exp_idle) begin
        nf = 1;
      end else if (exp_halt) begin
        halt_cycles++;
      end else if (exp_fetch) begin
        if (a) begin
          run = 0;
          if (partial) begin
            q.push_back({partial_op, d}); last_imm = d; partial = 0;
          end else if (d[15]) begin
            partial = 1; partial_op = d; nf = 1;
          end else begin
            q.push_back({d, last_imm});
          end
        end else begin
          run++;
          if (run >= 3) exp_halt = 1;
          else nf = 1;
        end
      end else if (q.size() > 0) begin
        if (rdy) begin
          void'(q.pop_front());
          if (jhold) nj = 1;
          else nf = 1;
        end
      end else if (exp_jack) begin
        nf = 1; jhold = 0;
      end
      exp_fetch = nf; exp_jack = nj; exp_idle = ni;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control-side counterpart of the 16-bit program counter: this block drives the counter and reads what it addresses.
- It drives the counter's output enable, increment and load controls, and requests memory reads at the counter's address.
- It latches the returned opcode word, plus an optional immediate word, and hands the instruction to the decoder over a valid/ready handshake.
- It converts jump requests from the execute stage into a counter load and stops with a sticky fault if memory fails to respond.

Parameters:
- DATA_WIDTH, 16: width of memData, instr, imm.
- IMM_BIT, 15: opcode bit that marks a two-word instruction (opcode followed by immediate).
- WAIT_LIMIT, 15: maximum wait cycles per memory read before fault; 1..255.

Ports:
- clock  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- pcNotOE  out  1  active-low enable of program counter onto address bus.
- pcInc  out  1  counter increment enable, effective at the next rising edge.
- pcNotLoad  out  1  active-low counter load from jump target bus.
- memReq  out  1  memory read request.
- memAck  in  1  memory read data valid on memData this cycle.
- memData  in  DATA_WIDTH  read data.
- instr  out  DATA_WIDTH  latched opcode word.
- imm  out  DATA_WIDTH  latched immediate word; holds its previous value for one-word instructions.
- instrValid  out  1  instr/imm valid for decoder.
- instrReady  in  1  decoder accepts instruction.
- jumpReq  in  1  execute stage requests a counter load; held high until jumpAck.
- jumpAck  out  1  one-cycle acknowledge of the load.
- fault  out  1  sticky memory timeout flag.

Behaviour:
Reset and state encoding
- Reset is synchronous and active-high. While reset is high at an edge the block enters IDLE and sets:
  - instr=0, imm=0, wait counter=0, fault=0.
  - Outputs: pcNotOE=1, pcInc=0, pcNotLoad=1, memReq=0, instrValid=0, jumpAck=0.
- Reset mid-operation (any state, including while memReq is high) aborts immediately. A memAck arriving in the reset cycle is ignored.
- States: IDLE, FETCH_OP, FETCH_IMM, ISSUE, JUMP, HALT.
- All outputs are decoded from state only (Moore), except pcInc, which is Mealy.

State transitions
- IDLE: lasts exactly one cycle, then goes to FETCH_OP.
- FETCH_OP and FETCH_IMM:
  - Outputs: pcNotOE=0, memReq=1.
  - pcInc = memAck, combinationally, so the counter advances on the same edge that the data is latched.
  - On memAck in FETCH_OP: instr<=memData. If memData[IMM_BIT]=1, go to FETCH_IMM; otherwise go to ISSUE.
  - On memAck in FETCH_IMM: imm<=memData, go to ISSUE.
- Wait counter:
  - Cleared on entry to each fetch state and on each memAck.
  - Increments every fetch cycle without memAck.
  - When it reaches WAIT_LIMIT with no memAck, the block goes to HALT.
  - An ack arriving exactly in the WAIT_LIMIT-th wait cycle is accepted; no fault.
- ISSUE:
  - instrValid=1. instr and imm are stable for the whole time instrValid is high.
  - Transfer occurs in the cycle with instrValid & instrReady.
  - On transfer: go to JUMP if jumpReq=1 in that cycle; otherwise go to FETCH_OP.
  - jumpReq without instrReady has no effect; the block stays in ISSUE.
- JUMP:
  - Lasts exactly one cycle: pcNotLoad=0, jumpAck=1, pcNotOE=1, memReq=0.
  - Then goes to FETCH_OP, which fetches from the new counter value.
- HALT:
  - fault=1, memReq=0, pcNotOE=1.
  - Remains in HALT until reset; jumpReq and memAck are ignored.

Boundary conditions and invariants
- pcInc and pcNotLoad=0 are never active in the same cycle.
- pcNotOE=0 only in the fetch states.
- Counter wrap from FFFF to 0000 is the counter's own behaviour. The sequencer fetches across the wrap with no special handling.
- instrValid never asserts for an instruction whose immediate has not yet been latched.

Test Plan:
- One-word fetch: reset, then memAck in the 2nd FETCH_OP cycle with memData=0x1234. Required: exactly one pcInc pulse, instr=0x1234, instrValid high the next cycle; with instrReady=1, next FETCH_OP one cycle later.
- Two-word fetch: memData=0x8001, then 0xBEEF. Required: two pcInc pulses, instr=0x8001, imm=0xBEEF, instrValid only after the second ack.
- Backpressure and jump: hold instrReady=0 for 5 cycles with jumpReq=1. Required: instr stable, no jumpAck. Then instrReady=1. Required: next cycle pcNotLoad=0 and jumpAck=1 for exactly 1 cycle, then FETCH_OP.
- Timeout with WAIT_LIMIT=3:
  - No ack. Required: HALT after the 3rd wait cycle, fault=1, memReq=0, fault persists; reset clears it.
  - Separate run with ack in the 3rd wait cycle. Required: no fault.
- Reset mid-fetch: assert reset with memReq=1 and memAck=1 in the same cycle. Required: instr=0, pcInc ignored, IDLE, then FETCH_OP after 1 cycle.
